clkmon: RTL

Clock monitor and frequency meter that consumes a divided clock, such as the output of the on-chip clock divider, and checks it against the system clock.
- Synchronises the monitored clock into the clk_i domain and counts its rising edges over a fixed gate window of clk_i cycles.
- Publishes each completed count with a one-cycle valid strobe.
- Flags overflow, in-range lock and a stopped ("stuck") monitored clock.
- Used at boot to confirm divider/PLL settings before downstream logic is released.

---
 rtl/clkmon_pkg.sv | 28 ++
 rtl/clkmon_sync_edge.sv | 34 +++
 rtl/clkmon.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/clkmon_pkg.sv
// Shared state encoding, parameter defaults and counter sizing helpers for the clock monitor.
// Declarations only: no latency, no flow control.
package clkmon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_e;

  localparam int unsigned GATE_CYCLES_DEF  = 1000;
  localparam int unsigned CNT_W_DEF        = 16;
  localparam int unsigned SYNC_STAGES_DEF  = 2;
  localparam int unsigned LO_LIM_DEF       = 480;
  localparam int unsigned HI_LIM_DEF       = 520;
  localparam int unsigned STUCK_CYCLES_DEF = 64;

  // Bits needed to hold 0..n inclusive (saturating counters park at n).
  function automatic int unsigned hold_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // The gate counter only ever holds 0..n-1.
  function automatic int unsigned gate_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clkmon_sync_edge.sv
// Brings an asynchronous clock into clk_i and emits a one-cycle pulse per rising edge.
// The pulse appears SYNC_STAGES+1 clk_i edges after the input rises; no backpressure.
module clkmon_sync_edge
  import clkmon_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/clkmon.sv
// Frequency meter: counts monitored-clock edges per GATE_CYCLES window, flags overflow, lock and stuck.
// Result is published the cycle after the window's last cycle; windows run back to back; no backpressure.
module clkmon
  import clkmon_pkg::*;
#(
  parameter int unsigned GATE_CYCLES  = GATE_CYCLES_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int unsigned LO_LIM       = LO_LIM_DEF,
  parameter int unsigned HI_LIM       = HI_LIM_DEF,
  parameter int unsigned STUCK_CYCLES = STUCK_CYCLES_DEF
) (
  input  logic             rst_i,
  input  logic             clk_i,
  input  logic             mclk_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             valid_o,
  output logic             ovf_o,
  output logic             lock_o,
  output logic             stuck_o
);

  localparam int unsigned GATE_W = gate_w(GATE_CYCLES);
  localparam int unsigned IDLE_W = hold_w(STUCK_CYCLES);
  localparam int unsigned ARM_W  = hold_w(SYNC_STAGES);

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] STUCK_MAX = IDLE_W'(STUCK_CYCLES);
  localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(SYNC_STAGES);

  state_e            state_q, state_d;
  logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic              sat_q, sat_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              good_q, good_d;
  logic              lock_q, lock_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;

  logic              mon_edge;
  logic              at_max;
  logic [CNT_W-1:0]  fin_cnt;
  logic              fin_sat;
  logic              fin_good;

  clkmon_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(mclk_i),
    .edge_o (mon_edge)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      arm_cnt_q  <= '0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      idle_cnt_q <= '0;
      good_q     <= 1'b0;
      lock_q     <= 1'b0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      idle_cnt_q <= idle_cnt_d;
      good_q     <= good_d;
      lock_q     <= lock_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en_i) state_d = ARM;
      ARM:     if (!en_i) state_d = IDLE;
               else if (arm_cnt_q == ARM_LAST) state_d = MEAS;
      MEAS:    if (!en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    at_max   = (edge_cnt_q == CNT_MAX);
    fin_cnt  = (mon_edge && !at_max) ? edge_cnt_q + 1'b1 : edge_cnt_q;
    fin_sat  = sat_q | (mon_edge & at_max);
    fin_good = !fin_sat && (32'(fin_cnt) >= LO_LIM) && (32'(fin_cnt) <= HI_LIM);

    arm_cnt_d  = (state_q == ARM && en_i && arm_cnt_q != ARM_LAST) ? arm_cnt_q + 1'b1 : '0;
    gate_cnt_d = '0;
    edge_cnt_d = '0;
    sat_d      = 1'b0;
    idle_cnt_d = '0;
    good_d     = 1'b0;
    lock_d     = 1'b0;
    cnt_d      = cnt_q;
    valid_d    = 1'b0;
    ovf_d      = ovf_q;

    if (state_q == MEAS && en_i) begin
      good_d = good_q;
      lock_d = lock_q;
      if (mon_edge)                    idle_cnt_d = '0;
      else if (idle_cnt_q != STUCK_MAX) idle_cnt_d = idle_cnt_q + 1'b1;
      else                             idle_cnt_d = idle_cnt_q;

      // The terminal cycle's edge is already folded into fin_cnt.
      if (gate_cnt_q == GATE_LAST) begin
        cnt_d   = fin_cnt;
        valid_d = 1'b1;
        ovf_d   = fin_sat;
        good_d  = fin_good;
        lock_d  = fin_good & good_q;
      end else begin
        gate_cnt_d = gate_cnt_q + 1'b1;
        edge_cnt_d = fin_cnt;
        sat_d      = fin_sat;
      end

      if (idle_cnt_d == STUCK_MAX && idle_cnt_q != STUCK_MAX) begin
        lock_d = 1'b0;
        good_d = 1'b0;
      end
    end
  end

  assign cnt_o   = cnt_q;
  assign valid_o = valid_q;
  assign ovf_o   = ovf_q;
  assign lock_o  = lock_q;
  assign stuck_o = (idle_cnt_q == STUCK_MAX);

endmodule
